ibex_alu_pext_mult: RTL

Multi-cycle P-extension multiply/accumulate unit in the EX stage. It sits beside the Pext ALU and consumes the same zpn operator encoding and helper decode outputs. It executes the 32-bit MSW/low-word multiply-accumulate ops and the 8/16-bit lane dot-product ops. It uses a single shared 17x17 signed multiplier, iterated over partial products. The EX stage stalls on it using the same enable/valid protocol as the Ibex multdiv unit.

---
 rtl/ibex_pkg_pext.sv | 93 +++++++++
 rtl/ibex_pext_mul17.sv | 17 +
 rtl/ibex_alu_pext_mult.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg_pext.sv
// Shared P-extension definitions: zpn operator encoding and the
// multiply/accumulate unit's state, mode bundle and mode decoder.
package ibex_pkg_pext;

    typedef enum logic [4:0] {
        ZPN_ADD16,
        ZPN_SUB16,
        ZPN_ADD8,
        ZPN_SUB8,
        ZPN_KMMAC,
        ZPN_KMMACU,
        ZPN_KMMSB,
        ZPN_KMMSBU,
        ZPN_MADDR32,
        ZPN_MSUBR32,
        ZPN_SMAQA,
        ZPN_UMAQA,
        ZPN_KMDA,
        ZPN_KMADA
    } zpn_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        ACC
    } pext_mult_state_e;

    typedef struct packed {
        logic [2:0] steps;
        logic       lane8;
        logic       lane16;
        logic       is_signed;
        logic       round;
        logic       sat;
        logic       acc_rd;
    } pext_mult_mode_t;

    localparam logic [31:0] PextSatMax = 32'h7fff_ffff;
    localparam logic [31:0] PextSatMin = 32'h8000_0000;

    // steps == 0 marks an operator this unit does not execute
    function automatic pext_mult_mode_t pext_mult_decode(input zpn_op_e op);
        pext_mult_mode_t m;
        m = '0;
        unique case (op)
            ZPN_KMMAC, ZPN_KMMSB: begin
                m.steps     = 3'd4;
                m.is_signed = 1'b1;
                m.sat       = 1'b1;
                m.acc_rd    = 1'b1;
            end
            ZPN_KMMACU, ZPN_KMMSBU: begin
                m.steps     = 3'd4;
                m.is_signed = 1'b1;
                m.round     = 1'b1;
                m.sat       = 1'b1;
                m.acc_rd    = 1'b1;
            end
            ZPN_MADDR32, ZPN_MSUBR32: begin
                m.steps     = 3'd4;
                m.is_signed = 1'b1;
                m.acc_rd    = 1'b1;
            end
            ZPN_SMAQA: begin
                m.steps     = 3'd4;
                m.lane8     = 1'b1;
                m.is_signed = 1'b1;
                m.acc_rd    = 1'b1;
            end
            ZPN_UMAQA: begin
                m.steps     = 3'd4;
                m.lane8     = 1'b1;
                m.acc_rd    = 1'b1;
            end
            ZPN_KMDA: begin
                m.steps     = 3'd2;
                m.lane16    = 1'b1;
                m.is_signed = 1'b1;
                m.sat       = 1'b1;
            end
            ZPN_KMADA: begin
                m.steps     = 3'd2;
                m.lane16    = 1'b1;
                m.is_signed = 1'b1;
                m.sat       = 1'b1;
                m.acc_rd    = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ibex_pext_mul17.sv
// Shared 17x17 signed multiplier, purely combinational so it can be
// swapped for a DSP primitive without touching the sequencing logic.
module ibex_pext_mul17 (
    input  logic [16:0] a_i,
    input  logic [16:0] b_i,
    output logic [33:0] p_o
);

    logic [33:0] a_ext;
    logic [33:0] b_ext;

    // the low 34 bits of the wide product equal the signed 34-bit product
    assign a_ext = {{17{a_i[16]}}, a_i};
    assign b_ext = {{17{b_i[16]}}, b_i};
    assign p_o   = a_ext * b_ext;

endmodule

// File: rtl/ibex_alu_pext_mult.sv
// Multi-cycle P-extension multiply/accumulate unit: one partial product
// per cycle through a shared 17x17 multiplier, result formed in ACC.
module ibex_alu_pext_mult
    import ibex_pkg_pext::*;
#(
    parameter int unsigned AccWidth = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mult_en_i,
    input  zpn_op_e     operator_i,
    input  logic [1:0]  alu_sub_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic [31:0] operand_c_i,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic        ov_o,
    output logic        busy_o
);

    pext_mult_state_e    state_q;
    logic [1:0]          step_q;
    logic [AccWidth-1:0] acc_q;

    pext_mult_mode_t     mode;
    logic [2:0]          last_step;
    logic                sub;
    logic                unused_sub;

    logic [7:0]          a_byte;
    logic [7:0]          b_byte;
    logic [15:0]         a_half;
    logic [15:0]         b_half;
    logic [16:0]         a_lo;
    logic [16:0]         a_hi;
    logic [16:0]         b_lo;
    logic [16:0]         b_hi;

    logic [16:0]         mul_a;
    logic [16:0]         mul_b;
    logic [5:0]          pp_shift;
    logic [33:0]         prod;
    logic [AccWidth-1:0] pp;

    logic [31:0]         acc_hi;
    logic [33:0]         rd_ext;
    logic [33:0]         term;
    logic [33:0]         sum;

    assign mode       = pext_mult_decode(operator_i);
    assign last_step  = mode.steps - 3'd1;
    assign sub        = alu_sub_i[0];
    assign unused_sub = alu_sub_i[1];

    assign a_byte = operand_a_i[{step_q, 3'b000} +: 8];
    assign b_byte = operand_b_i[{step_q, 3'b000} +: 8];
    assign a_half = step_q[0] ? operand_a_i[31:16] : operand_a_i[15:0];
    assign b_half = step_q[0] ? operand_b_i[31:16] : operand_b_i[15:0];

    // low halves are magnitudes, high halves carry the 32-bit sign
    assign a_lo = {1'b0, operand_a_i[15:0]};
    assign b_lo = {1'b0, operand_b_i[15:0]};
    assign a_hi = {mode.is_signed & operand_a_i[31], operand_a_i[31:16]};
    assign b_hi = {mode.is_signed & operand_b_i[31], operand_b_i[31:16]};

    always_comb begin
        mul_a    = '0;
        mul_b    = '0;
        pp_shift = '0;
        unique case (1'b1)
            mode.lane8: begin
                mul_a = {{9{mode.is_signed & a_byte[7]}}, a_byte};
                mul_b = {{9{mode.is_signed & b_byte[7]}}, b_byte};
            end
            mode.lane16: begin
                mul_a = {mode.is_signed & a_half[15], a_half};
                mul_b = {mode.is_signed & b_half[15], b_half};
            end
            default: begin
                unique case (step_q)
                    2'd0: begin
                        mul_a = a_lo;
                        mul_b = b_lo;
                    end
                    2'd1: begin
                        mul_a    = a_lo;
                        mul_b    = b_hi;
                        pp_shift = 6'd16;
                    end
                    2'd2: begin
                        mul_a    = a_hi;
                        mul_b    = b_lo;
                        pp_shift = 6'd16;
                    end
                    default: begin
                        mul_a    = a_hi;
                        mul_b    = b_hi;
                        pp_shift = 6'd32;
                    end
                endcase
            end
        endcase
    end

    ibex_pext_mul17 u_mul17 (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    assign pp = {{(AccWidth-34){prod[33]}}, prod} << pp_shift;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            step_q  <= '0;
            acc_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mult_en_i) begin
                        acc_q   <= '0;
                        step_q  <= '0;
                        state_q <= (mode.steps == 3'd0) ? ACC : MULT;
                    end
                end
                MULT: begin
                    if (!mult_en_i) begin
                        acc_q   <= '0;
                        step_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        acc_q  <= acc_q + pp;
                        step_q <= step_q + 2'd1;
                        if ({1'b0, step_q} == last_step) begin
                            state_q <= ACC;
                        end
                    end
                end
                ACC:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // adding 2^31 before taking P[63:32] only carries in through bit 31
    assign acc_hi = acc_q[63:32] + {31'b0, mode.round & acc_q[31]};
    assign rd_ext = mode.acc_rd ? {{2{operand_c_i[31]}}, operand_c_i} : '0;

    always_comb begin
        result_o = '0;
        ov_o     = 1'b0;
        term     = '0;
        sum      = '0;
        if (state_q == ACC && mode.steps != 3'd0) begin
            if (mode.lane8) begin
                result_o = operand_c_i + acc_q[31:0];
            end else if (!mode.sat) begin
                result_o = sub ? operand_c_i - acc_q[31:0]
                               : operand_c_i + acc_q[31:0];
            end else begin
                term = mode.lane16 ? acc_q[33:0]
                                   : {{2{acc_hi[31]}}, acc_hi};
                sum  = (sub && !mode.lane16) ? rd_ext - term
                                             : rd_ext + term;
                if (sum[33:31] == 3'b000 || sum[33:31] == 3'b111) begin
                    result_o = sum[31:0];
                end else begin
                    result_o = sum[33] ? PextSatMin : PextSatMax;
                    ov_o     = 1'b1;
                end
            end
        end
    end

    assign valid_o = (state_q == ACC);
    assign busy_o  = (state_q != IDLE);

endmodule
